// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU placed between the A/B operand registers
// and the HI/LO result pair. Single-cycle ops complete at the start edge.
// Multiply is an iterative shift-add engine and divide is a restoring engine.
// Both run one bit per clock and are controlled by a start/busy/done handshake.
// Optional build macro: ALU_FLAGS_EN adds the registered flags[3:0] = {N,Z,Cy,V}.
module seq_alu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] C,
    output logic               busy,
    output logic               done,
    output logic               dz
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_MUL  = 5'h03;
    localparam logic [4:0] OP_DIV  = 5'h04;
    localparam logic [4:0] OP_SHR  = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_SHRA = 5'h07;
    localparam logic [4:0] OP_ROR  = 5'h08;
    localparam logic [4:0] OP_ROL  = 5'h09;
    localparam logic [4:0] OP_AND  = 5'h0A;
    localparam logic [4:0] OP_OR   = 5'h0B;
    localparam logic [4:0] OP_NEG  = 5'h0C;
    localparam logic [4:0] OP_XOR  = 5'h0D;
    localparam logic [4:0] OP_NOR  = 5'h0E;
    localparam logic [4:0] OP_NOT  = 5'h0F;

    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [2*WIDTH-1:0] ZERO_2W  = {(2*WIDTH){1'b0}};
    localparam logic [SHW-1:0]     CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0]     CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};
    localparam logic [SHW-1:0]     CNT_LAST = {SHW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Two's complement helpers for single and double width values
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The magnitude of the most negative value is 2^(WIDTH-1), which still fits unsigned
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_w(x) : x;
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [SHW-1:0]     cnt_r;
    logic [WIDTH-1:0]   hi_r;       // partial product / partial remainder
    logic [WIDTH-1:0]   lo_r;       // multiplier / dividend-then-quotient
    logic [WIDTH-1:0]   mag_r;      // multiplicand / divisor magnitude
    logic               sign_a_r;
    logic               sign_b_r;
    logic               is_div_r;
    logic [2*WIDTH-1:0] c_r;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;

    logic [SHW-1:0]     sh_s;
    logic [2*WIDTH-1:0] rot_r_s;
    logic [2*WIDTH-1:0] rot_l_s;
    logic [2*WIDTH-1:0] sc_res_s;
    logic               sc_dz_s;
    logic               sc_load_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_trial_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] mul_res_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] fix_res_s;

    assign sh_s = B[SHW-1:0];

    // A single-cycle completion happens for any start in IDLE that does not launch an engine
    assign sc_load_s = (state_r == ST_IDLE) && start && (state_next_s == ST_IDLE);

    // Single-cycle result; HI is zero except for the divide-by-zero case
    always_comb begin
        sc_res_s = ZERO_2W;
        sc_dz_s  = 1'b0;
        rot_r_s  = {A, A} >> sh_s;
        rot_l_s  = {A, A} << sh_s;
        case (opcode)
            OP_ADD:  sc_res_s[WIDTH-1:0] = A + B;
            OP_SUB:  sc_res_s[WIDTH-1:0] = A - B;
            OP_SHR:  sc_res_s[WIDTH-1:0] = A >> sh_s;
            OP_SHL:  sc_res_s[WIDTH-1:0] = A << sh_s;
            OP_SHRA: sc_res_s[WIDTH-1:0] = $signed(A) >>> sh_s;
            OP_ROR:  sc_res_s[WIDTH-1:0] = rot_r_s[WIDTH-1:0];
            OP_ROL:  sc_res_s[WIDTH-1:0] = rot_l_s[2*WIDTH-1:WIDTH];
            OP_AND:  sc_res_s[WIDTH-1:0] = A & B;
            OP_OR:   sc_res_s[WIDTH-1:0] = A | B;
            OP_NEG:  sc_res_s[WIDTH-1:0] = neg_w(B);
            OP_XOR:  sc_res_s[WIDTH-1:0] = A ^ B;
            OP_NOR:  sc_res_s[WIDTH-1:0] = ~(A | B);
            OP_NOT:  sc_res_s[WIDTH-1:0] = ~B;
            OP_DIV: begin
                // only reached with B == 0: report the dividend and an all-ones quotient
                sc_res_s = {A, ONES_W};
                sc_dz_s  = 1'b1;
            end
            default: sc_res_s = ZERO_2W;
        endcase
    end

    // One iteration step of each engine, plus the sign fix-up of the final magnitudes
    always_comb begin
        mul_sum_s   = lo_r[0] ? ({1'b0, hi_r} + {1'b0, mag_r}) : {1'b0, hi_r};
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, mag_r};
        prod_s      = {hi_r, lo_r};
        mul_res_s   = (sign_a_r ^ sign_b_r) ? neg_2w(prod_s) : prod_s;
        quo_s       = (sign_a_r ^ sign_b_r) ? neg_w(lo_r) : lo_r;
        rem_s       = sign_a_r ? neg_w(hi_r) : hi_r;
        fix_res_s   = is_div_r ? {rem_s, quo_s} : mul_res_s;
    end

    // Next-state logic: engines run WIDTH steps, then spend one cycle in FIX
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (opcode == OP_MUL)) begin
                    state_next_s = ST_MUL;
                end else if (start && (opcode == OP_DIV) && (B != ZERO_W)) begin
                    state_next_s = ST_DIV;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            ST_FIX:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand capture, engine iteration and result/handshake registers
    always_ff @(posedge clk) begin
        if (!clr) begin
            cnt_r    <= CNT_ZERO;
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
            mag_r    <= ZERO_W;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            is_div_r <= 1'b0;
            c_r      <= ZERO_2W;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (state_next_s == ST_MUL) begin
                        mag_r    <= abs_w(A);
                        lo_r     <= abs_w(B);
                        hi_r     <= ZERO_W;
                        sign_a_r <= A[WIDTH-1];
                        sign_b_r <= B[WIDTH-1];
                        is_div_r <= 1'b0;
                        cnt_r    <= CNT_ZERO;
                        busy_r   <= 1'b1;
                    end else if (state_next_s == ST_DIV) begin
                        mag_r    <= abs_w(B);
                        lo_r     <= abs_w(A);
                        hi_r     <= ZERO_W;
                        sign_a_r <= A[WIDTH-1];
                        sign_b_r <= B[WIDTH-1];
                        is_div_r <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                        busy_r   <= 1'b1;
                    end else if (sc_load_s) begin
                        c_r    <= sc_res_s;
                        dz_r   <= sc_dz_s;
                        done_r <= 1'b1;
                    end
                end
                ST_MUL: begin
                    hi_r  <= mul_sum_s[WIDTH:1];
                    lo_r  <= {mul_sum_s[0], lo_r[WIDTH-1:1]};
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        busy_r <= 1'b0;
                    end
                end
                ST_DIV: begin
                    if (!div_trial_s[WIDTH]) begin
                        hi_r <= div_trial_s[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_r <= div_shift_s[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FIX: begin
                    c_r    <= fix_res_s;
                    dz_r   <= 1'b0;
                    done_r <= 1'b1;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign C    = c_r;
    assign busy = busy_r;
    assign done = done_r;
    assign dz   = dz_r;

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] add_ext_s;
    logic [WIDTH:0] sub_ext_s;
    logic [3:0]     sc_flags_s;
    logic [3:0]     fix_flags_s;
    logic [3:0]     flags_r;

    // Flags for single-cycle and engine results; carry/overflow only for add/sub
    always_comb begin
        add_ext_s   = {1'b0, A} + {1'b0, B};
        sub_ext_s   = {1'b0, A} - {1'b0, B};
        sc_flags_s  = {sc_res_s[WIDTH-1], (sc_res_s == ZERO_2W), 2'b00};
        fix_flags_s = {fix_res_s[2*WIDTH-1], (fix_res_s == ZERO_2W), 2'b00};
        case (opcode)
            OP_ADD: begin
                sc_flags_s[1] = add_ext_s[WIDTH];
                sc_flags_s[0] = (A[WIDTH-1] == B[WIDTH-1]) && (add_ext_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_flags_s[1] = ~sub_ext_s[WIDTH];
                sc_flags_s[0] = (A[WIDTH-1] != B[WIDTH-1]) && (sub_ext_s[WIDTH-1] != A[WIDTH-1]);
            end
            OP_DIV:  sc_flags_s[3] = sc_res_s[2*WIDTH-1];
            default: sc_flags_s[0] = 1'b0;
        endcase
    end

    // Flags register, updated at the same edges as C
    always_ff @(posedge clk) begin
        if (!clr) begin
            flags_r <= 4'b0000;
        end else if (sc_load_s) begin
            flags_r <= sc_flags_s;
        end else if (state_r == ST_FIX) begin
            flags_r <= fix_flags_s;
        end
    end

    assign flags = flags_r;
`endif

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle successor to the single-cycle 32-bit datapath ALU. It keeps the same 5-bit opcode set. Single-cycle ops complete in 1 clock. Multiply and divide run as iterative shift-add and restoring-divide engines, with signed semantics and a start/busy/done handshake, so the control unit can stall on long ops. Sits between the operand registers (A/B) and the Z register pair (HI/LO) of the CPU datapath.

Parameters:
WIDTH, 32, operand width in bits; result is 2*WIDTH; must be a power of 2, >= 8
SHW, $clog2(WIDTH), shift-amount bits taken from B (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
clr  in  1  synchronous active-low reset
start  in  1  launch op; sampled only when busy=0
opcode  in  5  operation select, encoding below
A  in  WIDTH  operand A
B  in  WIDTH  operand B; also shift/rotate amount, neg/not source
C  out  2*WIDTH  result; HI=C[2W-1:W], LO=C[W-1:0]
busy  out  1  high while mul/div iterating
done  out  1  one-cycle pulse: C valid and updated this cycle
dz  out  1  divide-by-zero flag, registered with C

Behaviour:
- Reset (clr=0 at posedge): C=0, busy=0, done=0, dz=0, state=IDLE, iteration counter=0. Reset mid-operation aborts it; no done pulse for the aborted op.
- Opcodes: 01 add, 02 sub, 03 mul, 04 div, 05 shr, 06 shl, 07 shra, 08 ror, 09 rol, 0A and, 0B or, 0C neg, 0D xor, 0E nor, 0F not. Any other value: C=0, dz=0, done pulse.
- Single-cycle ops: start=1 at edge N loads C at edge N; done=1 for the cycle after edge N. HI=0. add/sub wrap modulo 2^WIDTH. Shifts/rotates act on A by B[SHW-1:0]. shra sign-fills. neg = two's complement of B; not = ~B.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start, mul/div: latch operand magnitudes and signs; busy=1; go to MUL/DIV; counter=0.
- MUL/DIV: one bit per clock for WIDTH clocks. Restoring division operates on magnitudes. At counter=WIDTH-1, go to FIX.
- FIX: apply signs. Write C (mul: 2W-bit signed product; div: HI=remainder, LO=quotient). busy=0. done pulse in the following cycle. Return to IDLE.
- Latency for mul/div: done asserted WIDTH+1 cycles after the start edge (33 for WIDTH=32).
- Division truncates toward zero; remainder takes the dividend's sign. MIN / -1 gives quotient=MIN, remainder=0 (no trap).
- Divide by zero is detected in IDLE and completes as a single-cycle op: LO=all ones, HI=A, dz=1. dz clears on the next completed op.
- start while busy=1 is ignored. Operands are latched, so A/B/opcode may change while busy.
- C holds its value between completions. done never asserts while busy=1.
- clr=0 and start=1 in the same cycle: reset wins.

Optional Feature:
ALU_FLAGS_EN:
- Defined: adds output port flags[3:0] = {N,Z,Cy,V}, registered at the same edge as C.
- N = MSB of the result: C[2W-1] for mul/div, C[W-1] otherwise.
- Z = all result bits zero.
- Cy and V valid for add/sub only (Cy = carry-out / not-borrow); 0 for all other ops.
- Flags reset to 0.
- Undefined: port and logic absent.

Test Plan:
1. add A=0x7FFFFFFF, B=1 -> next cycle C=0x00000000_80000000, done=1, busy=0. With ALU_FLAGS_EN: flags=4'b1001.
2. mul A=0xFFFFFFFD (-3), B=7 -> busy high 32 cycles; done 33 cycles after start; C=0xFFFFFFFF_FFFFFFEB. start pulsed mid-op is ignored, C unchanged until done.
3. div A=0xFFFFFFEF (-17), B=5 -> C=0xFFFFFFFE_FFFFFFFD after 33 cycles, dz=0.
4. div A=0x00001234, B=0 -> 1 cycle: C=0x00001234_FFFFFFFF, dz=1. Following add 1+1 -> C=2, dz=0.
5. shra A=0x80000010, B=4 -> C low=0xF8000001. ror A=1, B=1 -> 0x80000000. rol A=0x80000000, B=33 -> 0x00000001.
6. Start mul, drive clr=0 at cycle 10 -> next edge C=0, busy=0, no done ever. Then opcode 0x1F -> C=0, done pulse.
